// File: rtl/seg7_port_display.sv
// -----------------------------------------------------------------------------
// seg7_port_display
//
// Port-mapped, time-multiplexed driver for a 4-digit common-anode 7-segment
// display, sitting directly on the KCPSM6 output bus.
//
// The processor writes into a shadow register set. The shadow set is copied
// to the displayed (active) set either on every frame wrap or one cycle after
// a write to the commit port, so a half-updated value never reaches the
// display. Each digit slot opens with a dead-time window in which every anode
// is off, which suppresses ghosting between adjacent digits.
//
// Port map (write-only, any other port_id is ignored):
//   BASE_PORT+0 : digit1 <= out_port[7:4], digit0 <= out_port[3:0]
//   BASE_PORT+1 : digit3 <= out_port[7:4], digit2 <= out_port[3:0]
//   BASE_PORT+2 : dp_en  <= out_port[7:4], blank  <= out_port[3:0]
//   BASE_PORT+3 : any data requests a forced commit
//
// Parameters:
//   BASE_PORT   - first of four consecutive port IDs
//   REFRESH_DIV - cycles each digit is selected (>= 2)
//   DEAD_CYCLES - anodes-off cycles at the start of each slot (< REFRESH_DIV)
//
// Ports:
//   CLK          - single clock, rising edge
//   rst          - asynchronous reset, active low
//   port_id      - processor port address
//   out_port     - processor write data
//   write_strobe - one-cycle write qualifier
//   seg          - segments, active low, seg[7]=dp, seg[6:0]=g..a (registered)
//   an           - anodes, active low, an[0]=rightmost digit (registered)
//   frame_tick   - one-cycle pulse after each digit 3 -> digit 0 wrap
// -----------------------------------------------------------------------------
module seg7_port_display #(
  parameter logic [7:0] BASE_PORT   = 8'h10,
  parameter int         REFRESH_DIV = 100000,
  parameter int         DEAD_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PCNT_DEAD = PW'(DEAD_CYCLES);

  localparam logic [7:0] PORT_DIG_LO = BASE_PORT;
  localparam logic [7:0] PORT_DIG_HI = BASE_PORT + 8'd1;
  localparam logic [7:0] PORT_CTRL   = BASE_PORT + 8'd2;
  localparam logic [7:0] PORT_COMMIT = BASE_PORT + 8'd3;

  // One complete displayable image: four hex digits plus per-digit flags.
  typedef struct packed {
    logic [3:0][3:0] digit;
    logic [3:0]      blank;
    logic [3:0]      dp_en;
  } disp_t;

  // Out of reset every digit is blanked so nothing lights before software
  // has written real content.
  localparam disp_t DISP_RESET = '{digit: '0, blank: 4'hF, dp_en: 4'h0};

  // Hex to active-low g..a pattern.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic wr_dig_lo;
  logic wr_dig_hi;
  logic wr_ctrl;
  logic wr_commit;

  assign wr_dig_lo = write_strobe && (port_id == PORT_DIG_LO);
  assign wr_dig_hi = write_strobe && (port_id == PORT_DIG_HI);
  assign wr_ctrl   = write_strobe && (port_id == PORT_CTRL);
  assign wr_commit = write_strobe && (port_id == PORT_COMMIT);

  // ---------------------------------------------------------------------------
  // Scan timing: pcnt walks through one slot, idx selects the digit.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pcnt;
  logic [1:0]    idx;
  logic          slot_end;
  logic          frame_wrap;

  assign slot_end   = (pcnt == PCNT_LAST);
  assign frame_wrap = slot_end && (idx == 2'd3);

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample pre-edge values; that is what lets a commit see the shadow set as
  // it was before a coincident shadow write.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
      idx  <= 2'd0;
    end else begin
      pcnt <= slot_end ? '0 : pcnt + 1'b1;
      if (slot_end) idx <= idx + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow / active image and commit
  // ---------------------------------------------------------------------------
  disp_t shadow;
  disp_t active;
  logic  commit_pend;

  // NOTE: the image registers are only 48 flops, not a RAM, so they take the
  // asynchronous reset like everything else and come up blanked.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      shadow <= DISP_RESET;
    end else begin
      if (wr_dig_lo) begin
        shadow.digit[0] <= out_port[3:0];
        shadow.digit[1] <= out_port[7:4];
      end
      if (wr_dig_hi) begin
        shadow.digit[2] <= out_port[3:0];
        shadow.digit[3] <= out_port[7:4];
      end
      if (wr_ctrl) begin
        shadow.blank <= out_port[3:0];
        shadow.dp_en <= out_port[7:4];
      end
    end
  end

  // A forced commit lands one edge after its strobe. If that edge is also a
  // frame wrap, both requests collapse into the same single copy.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      commit_pend <= 1'b0;
      active      <= DISP_RESET;
    end else begin
      commit_pend <= wr_commit;
      if (commit_pend || frame_wrap) active <= shadow;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (registered, so one cycle behind idx/pcnt/active)
  // ---------------------------------------------------------------------------
  logic       lit;
  logic [7:0] seg_d;
  logic [3:0] an_d;

  assign lit = (pcnt >= PCNT_DEAD) && !active.blank[idx];

  // NOTE: defaults first so every path assigns both outputs and no latch is
  // inferred; the dark pattern is also the natural default.
  always_comb begin
    seg_d = 8'hFF;
    an_d  = 4'hF;
    if (lit) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = {~active.dp_en[idx], hex7(active.digit[idx])};
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      seg        <= 8'hFF;
      an         <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_d;
      an         <= an_d;
      frame_tick <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg7_port_display.sv
// -----------------------------------------------------------------------------
// tb_seg7_port_display
//
// Directed bench for seg7_port_display with a small scan/commit model that
// predicts seg/an/frame_tick every cycle from elapsed cycles since reset,
// plus hand-computed slot expectations for the display contents.
// -----------------------------------------------------------------------------
module tb_seg7_port_display;

  localparam logic [7:0] BASE  = 8'h10;
  localparam int         RD    = 4;
  localparam int         DEAD  = 1;
  localparam int         FRAME = 4 * RD;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] port_id = 8'h00;
  logic [7:0] out_port = 8'h00;
  logic       write_strobe = 1'b0;
  logic [7:0] seg;
  logic [3:0] an;
  logic       frame_tick;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  seg7_port_display #(
    .BASE_PORT  (BASE),
    .REFRESH_DIV(RD),
    .DEAD_CYCLES(DEAD)
  ) dut (
    .CLK         (CLK),
    .rst         (rst),
    .port_id     (port_id),
    .out_port    (out_port),
    .write_strobe(write_strobe),
    .seg         (seg),
    .an          (an),
    .frame_tick  (frame_tick)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: scan position is derived from the cycle count since reset release.
  // ---------------------------------------------------------------------------
  int         m_t;
  logic [3:0] sh_d [4];
  logic [3:0] ac_d [4];
  logic [3:0] sh_bl, ac_bl, sh_dp, ac_dp;
  bit         m_pend;
  logic [7:0] e_seg;
  logic [3:0] e_an;
  logic       e_ft;

  initial forever begin
    @(posedge CLK or negedge rst);
    if (!rst) begin
      m_t = 0;
      for (int k = 0; k < 4; k++) begin sh_d[k] = 4'h0; ac_d[k] = 4'h0; end
      sh_bl = 4'hF; ac_bl = 4'hF; sh_dp = 4'h0; ac_dp = 4'h0;
      m_pend = 1'b0;
      e_seg = 8'hFF; e_an = 4'hF; e_ft = 1'b0;
    end else begin
      int  p, i;
      bit  on, wrap;
      p    = m_t % RD;
      i    = (m_t / RD) % 4;
      on   = (p >= DEAD) && !ac_bl[i];
      e_an  = on ? ~(4'b0001 << i) : 4'hF;
      e_seg = on ? {~ac_dp[i], SEG_TAB[ac_d[i]]} : 8'hFF;
      wrap = (m_t % FRAME) == FRAME - 1;
      e_ft = wrap;
      if (m_pend || wrap) begin
        ac_d = sh_d; ac_bl = sh_bl; ac_dp = sh_dp;
      end
      m_pend = write_strobe && (port_id == BASE + 8'd3);
      if (write_strobe) begin
        if (port_id == BASE)        begin sh_d[0] = out_port[3:0]; sh_d[1] = out_port[7:4]; end
        if (port_id == BASE + 8'd1) begin sh_d[2] = out_port[3:0]; sh_d[3] = out_port[7:4]; end
        if (port_id == BASE + 8'd2) begin sh_bl   = out_port[3:0]; sh_dp   = out_port[7:4]; end
      end
      m_t++;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (cmp_en) begin
      check("model seg", seg, e_seg);
      check("model an", an, e_an);
      check("model frame_tick", frame_tick, e_ft);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic sync();
    @(posedge CLK); #1;
  endtask

  // Called at posedge+1; returns at the following posedge+1, so consecutive
  // calls produce back-to-back strobes.
  task automatic write(input logic [7:0] p, input logic [7:0] d);
    port_id = p; out_port = d; write_strobe = 1'b1;
    @(posedge CLK); #1;
    write_strobe = 1'b0;
  endtask

  task automatic wait_tick();
    int w;
    w = 0;
    do begin @(negedge CLK); w++; end while (!frame_tick && w < 3 * FRAME);
    check("frame_tick seen", frame_tick, 1'b1);
  endtask

  // Waits for the next lit slot and checks its anode, pattern and length.
  task automatic next_lit(input string name, input logic [3:0] ea,
                          input logic [7:0] es, input bit chk_len);
    int w, len;
    w = 0;
    do begin @(negedge CLK); w++; end while (an == 4'hF && w < 3 * FRAME);
    check({name, " an"}, an, ea);
    check({name, " seg"}, seg, es);
    if (an != 4'hF) begin
      len = 1;
      forever begin
        @(negedge CLK);
        if (an != ea || len > FRAME) break;
        len++;
      end
      if (chk_len) begin
        check({name, " lit length"}, len, RD - DEAD);
        check({name, " dead gap"}, an, 4'hF);
      end
    end
  endtask

  task automatic count_lit(input string name, input int cycles);
    int lit_cnt;
    lit_cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge CLK);
      if (an != 4'hF || seg != 8'hFF) lit_cnt++;
    end
    check(name, lit_cnt, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int w;

    // Reset and blanked start.
    #2 rst = 1'b0;
    cmp_en = 1'b1;
    #1;
    check("reset an", an, 4'hF);
    check("reset seg", seg, 8'hFF);
    check("reset frame_tick", frame_tick, 1'b0);
    @(negedge CLK); @(negedge CLK); #2 rst = 1'b1;
    count_lit("lit while blanked after reset", 2 * FRAME);

    // Digits 1,2,3,4 with forced commit, checked over a whole frame.
    sync();
    write(BASE,        8'h21);
    write(BASE + 8'd1, 8'h43);
    write(BASE + 8'd2, 8'h00);
    write(BASE + 8'd3, 8'h5C);
    wait_tick();
    next_lit("digit0 '1'", 4'hE, 8'hF9, 1'b1);
    next_lit("digit1 '2'", 4'hD, 8'hA4, 1'b1);
    next_lit("digit2 '3'", 4'hB, 8'hB0, 1'b1);
    next_lit("digit3 '4'", 4'h7, 8'h99, 1'b1);

    // Shadow write without commit stays hidden until the frame wrap.
    wait_tick();
    sync();
    write(BASE, 8'h88);
    next_lit("old digit0", 4'hE, 8'hF9, 1'b0);
    next_lit("old digit1", 4'hD, 8'hA4, 1'b1);
    next_lit("old digit2", 4'hB, 8'hB0, 1'b1);
    next_lit("old digit3", 4'h7, 8'h99, 1'b1);
    next_lit("new digit0", 4'hE, 8'h80, 1'b1);
    next_lit("new digit1", 4'hD, 8'h80, 1'b1);

    // Blank digit1, decimal points on digits 0 and 2.
    sync();
    write(BASE + 8'd2, 8'h52);
    write(BASE + 8'd3, 8'h00);
    wait_tick();
    next_lit("dp digit0", 4'hE, 8'h00, 1'b1);
    next_lit("dp digit2 (digit1 blank)", 4'hB, 8'h30, 1'b1);
    next_lit("no dp digit3", 4'h7, 8'h99, 1'b1);

    // Shadow write on the exact frame-wrap edge.
    wait_tick();
    sync();
    write(BASE + 8'd2, 8'h00);
    write(BASE,        8'h66);
    w = 0;
    while ((m_t % FRAME) != FRAME - 1 && w < 2 * FRAME) begin sync(); w++; end
    write(BASE, 8'hA5);
    wait_tick();
    next_lit("wrap-edge old digit0", 4'hE, 8'h82, 1'b1);
    next_lit("wrap-edge old digit1", 4'hD, 8'h82, 1'b1);
    next_lit("wrap-edge digit2", 4'hB, 8'hB0, 1'b1);
    next_lit("wrap-edge digit3", 4'h7, 8'h99, 1'b1);
    next_lit("wrap-edge new digit0", 4'hE, 8'h92, 1'b1);
    next_lit("wrap-edge new digit1", 4'hD, 8'h88, 1'b1);

    // Writes outside the port window are ignored.
    sync();
    write(BASE + 8'd4, 8'hFF);
    write(8'h00,       8'h3C);
    write(8'h13 ^ 8'h80, 8'h11);
    wait_tick();
    next_lit("ignored digit0", 4'hE, 8'h92, 1'b1);
    next_lit("ignored digit1", 4'hD, 8'h88, 1'b1);
    next_lit("ignored digit2", 4'hB, 8'hB0, 1'b1);
    next_lit("ignored digit3", 4'h7, 8'h99, 1'b1);

    // Asynchronous reset while a digit is lit; writes during reset are lost.
    w = 0;
    do begin @(negedge CLK); w++; end while (an == 4'hF && w < FRAME);
    check("lit before mid-scan reset", an == 4'hF, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("mid-scan reset an", an, 4'hF);
    check("mid-scan reset seg", seg, 8'hFF);
    check("mid-scan reset frame_tick", frame_tick, 1'b0);
    sync();
    write(BASE + 8'd2, 8'h00);
    write(BASE + 8'd3, 8'h00);
    @(negedge CLK); #2 rst = 1'b1;
    count_lit("lit after mid-scan reset", 2 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_port_display.md
# seg7_port_display

Port-mapped, time-multiplexed driver for a 4-digit common-anode 7-segment display. It sits directly downstream of the KCPSM6 output bus and decodes `port_id`, `out_port` and `write_strobe`. Written values go into shadow registers. A frame-synchronous or software-forced commit copies them to the displayed set, so the display never tears. Output is hex decoding with per-digit blanking, decimal points, and anode dead-time for ghost suppression.

## Interface
- `BASE_PORT`, 8'h10: first of four consecutive port IDs.
- `REFRESH_DIV`, 100000: cycles each digit is selected. Must be at least 2.
- `DEAD_CYCLES`, 16: cycles with all anodes off after each digit change. Must be at least 0 and less than `REFRESH_DIV`.
- `CLK` input 1: single clock. All state is updated on the rising edge.
- `rst` input 1: asynchronous, active-low reset (asserted when 0).
- `port_id` input 8: processor port address.
- `out_port` input 8: processor write data.
- `write_strobe` input 1: one-cycle write qualifier.
- `seg` output 8: segment drive, active-low. `seg[7]`=dp, `seg[6:0]`=g,f,e,d,c,b,a.
- `an` output 4: anode enables, active-low. `an[0]` is the rightmost digit.
- `frame_tick` output 1: one-cycle pulse on each frame wrap (digit 3 to digit 0).

## Operation
- Port map (write-only; writes to any other `port_id` are ignored):
  - `BASE_PORT+0`: shadow digit0 = `out_port[3:0]`, digit1 = `out_port[7:4]`.
  - `BASE_PORT+1`: shadow digit2 = `out_port[3:0]`, digit3 = `out_port[7:4]`.
  - `BASE_PORT+2`: shadow `blank[3:0]` = `out_port[3:0]`, `dp_en[3:0]` = `out_port[7:4]`.
  - `BASE_PORT+3`: any data value requests a forced commit.
- Shadow registers are written on the edge where `write_strobe`=1 and `port_id` matches.
- Commit copies all shadow registers (4 digits, blank, dp_en) to the active set. It occurs:
  - on the edge where the prescaler ends digit 3 (frame wrap), or
  - on the edge after a `BASE_PORT+3` write is strobed.
- A commit uses shadow values as they were before that same edge. A shadow write coincident with a commit is kept and shown at the next commit.
- A frame wrap coincident with a pending forced commit produces a single commit with no other side effect.
- Prescaler `pcnt` counts 0 to `REFRESH_DIV`-1 and wraps. When `pcnt`=`REFRESH_DIV`-1, digit index `idx` (2 bits) increments, wrapping 3 to 0.
- `frame_tick` = 1 on the cycle after `idx` changes from 3 to 0.
- Dead-time: while `pcnt` < `DEAD_CYCLES`, `an`=4'hF.
- Otherwise:
  - `an` = active-low one-hot of `idx`.
  - If `blank[idx]`=1, `an` stays 4'hF for that slot; the scan timing is unchanged.
- Hex decode, `seg[6:0]`: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- `seg[7]` = ~`dp_en[idx]`. `seg` = 8'hFF whenever `an`=4'hF.

## Timing
- Reset (`rst`=0, immediate, asynchronous):
  - shadow and active digits = 0; shadow and active `blank` = 4'hF; `dp_en` = 0.
  - `pcnt` = 0, `idx` = 0, pending commit cleared.
  - `an` = 4'hF, `seg` = 8'hFF, `frame_tick` = 0.
- `seg`, `an` and `frame_tick` are registered. They reflect `idx`, `pcnt` and the active set with 1-cycle latency.
- Reset release mid-frame restarts scanning at digit 0, dead-time first. Writes strobed during reset are lost.
- Forced commit latency:
  - strobe at edge N: active set updated at edge N+1;
  - visible on `seg` at edge N+2 if the current slot is lit.
- Frame period = 4×`REFRESH_DIV` cycles. Each digit is lit for `REFRESH_DIV`−`DEAD_CYCLES` cycles per frame.
- Back-to-back writes on consecutive cycles are all accepted, with no stall or handshake. The last write before a commit wins.

## Test plan
1. Bench parameters `REFRESH_DIV`=4, `DEAD_CYCLES`=1. Pulse `rst`=0 mid-scan:
   - `an`=F, `seg`=FF immediately, with no clock edge needed;
   - after release, no digit is lit until shadow/commit writes occur, since all digits are blanked.
2. Write `BASE+0`=8'h21, `BASE+1`=8'h43, `BASE+2`=8'h00, then `BASE+3`. Over the next frame, expect:
   - `an`=E with `seg`=F9 (digit 1); `an`=D with `seg`=A4 (digit 2);
   - `an`=B with `seg`=B0 (digit 3); `an`=7 with `seg`=99 (digit 4);
   - each lit for 3 cycles, separated by one cycle of `an`=F.
3. With digits committed, write `BASE+0`=8'h88 without a commit. The display is unchanged until the next `frame_tick`, then digit0 and digit1 show `seg`=80.
4. Write `BASE+2`=8'h52 and commit:
   - digit1 slot is `an`=F, `seg`=FF;
   - digit0 and digit2 show `seg[7]`=0;
   - digit3 shows `seg[7]`=1.
5. Strobe a `BASE+0` write on the exact frame-wrap edge. The old shadow value is committed, and the new value appears only after the following `frame_tick`.
6. Write to port `BASE+4` and to 8'h00 with arbitrary data. No register changes and `seg`/`an` are unaffected.
